// File: rtl/alu_rs_pkg.sv
// Shared widths, encodings and entry layout for the ALU reservation station.
// Also provides the operand snoop helper used by dispatch and wake-up.
package alu_rs_pkg;

  localparam int INSIDE_OPCODE_WIDTH = 6;
  localparam int DATA_WIDTH          = 32;
  localparam int ROB_TAG_WIDTH       = 4;
  localparam int RS_ENTRIES          = 16;

  typedef logic [INSIDE_OPCODE_WIDTH-1:0] op_t;
  typedef logic [DATA_WIDTH-1:0]          data_t;
  typedef logic [ROB_TAG_WIDTH-1:0]       tag_t;

  localparam op_t   NOP          = '0;
  localparam data_t ZERO_DATA    = '0;
  localparam tag_t  ZERO_TAG_ROB = '0;

  // A source operand: the value is meaningful only once tag is ZERO_TAG_ROB.
  typedef struct packed {
    tag_t  tag;
    data_t value;
  } operand_t;

  typedef struct packed {
    logic  busy;
    op_t   op;
    data_t v1;
    tag_t  t1;
    data_t v2;
    tag_t  t2;
    data_t imm;
    data_t pc;
    tag_t  rob_tag;
  } rs_entry_t;

  typedef struct packed {
    op_t   op;
    data_t value1;
    data_t value2;
    data_t imm;
    data_t pc;
    tag_t  rob_tag;
  } issue_t;

  localparam issue_t ISSUE_IDLE = '0;

  // Resolve a pending operand against both result broadcasts.
  function automatic operand_t snoop(operand_t src,
                                     tag_t     alu_tag,
                                     data_t    alu_value,
                                     tag_t     lsb_tag,
                                     data_t    lsb_value);
    operand_t r;
    r = src;
    if (src.tag != ZERO_TAG_ROB) begin
      if (src.tag == alu_tag) begin
        r.tag   = ZERO_TAG_ROB;
        r.value = alu_value;
      end else if (src.tag == lsb_tag) begin
        r.tag   = ZERO_TAG_ROB;
        r.value = lsb_value;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue bundle from the reservation station to the combinational ALU.
// The station is the master; the ALU consumes it as slave.
interface alu_rs_if;
  import alu_rs_pkg::*;

  op_t   op;
  data_t value1;
  data_t value2;
  data_t imm;
  data_t pc;
  tag_t  rob_tag;

  modport master (
    output op, value1, value2, imm, pc, rob_tag
  );

  modport slave (
    input op, value1, value2, imm, pc, rob_tag
  );

endinterface

// File: rtl/alu_rs_select.sv
// Lowest-index-first priority encoder: reports whether any bit of vec_i is set
// and the index of the lowest set bit.
module rs_select #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic         found_o,
  output logic [W-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    found_o = |vec_i;
    index_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[N-1-i]) begin
        index_o = W'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched instructions,
// snoops ALU/LSB broadcasts and issues the lowest-index ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_ENTRIES
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  input  logic  in_clear,
  input  logic  in_dispatch,
  input  op_t   in_op,
  input  data_t in_value1,
  input  data_t in_value2,
  input  tag_t  in_tag1,
  input  tag_t  in_tag2,
  input  data_t in_imm,
  input  data_t in_pc,
  input  tag_t  in_rob_tag,
  input  tag_t  in_alu_tag,
  input  data_t in_alu_value,
  input  tag_t  in_lsb_tag,
  input  data_t in_lsb_value,
  output logic  out_full,
  alu_rs_if.master alu
);

  localparam int IDX_W = $clog2(RS_SIZE);

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];
  issue_t    out_q;
  issue_t    out_d;

  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               ready_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   ready_idx;
  logic [IDX_W:0]     busy_cnt;

  always_comb begin
    busy_cnt = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = !ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy &&
                     (ent_q[i].t1 == ZERO_TAG_ROB) &&
                     (ent_q[i].t2 == ZERO_TAG_ROB);
      busy_cnt     = busy_cnt + (IDX_W+1)'(ent_q[i].busy);
    end
  end

  // One slot of slack covers the dispatch already in flight when full rises.
  assign out_full = (busy_cnt >= (IDX_W+1)'(RS_SIZE - 1));

  rs_select #(
    .N (RS_SIZE),
    .W (IDX_W)
  ) u_free_sel (
    .vec_i   (free_vec),
    .found_o (free_found),
    .index_o (free_idx)
  );

  rs_select #(
    .N (RS_SIZE),
    .W (IDX_W)
  ) u_ready_sel (
    .vec_i   (ready_vec),
    .found_o (ready_found),
    .index_o (ready_idx)
  );

  always_comb begin
    ent_d = ent_q;
    out_d = out_q;

    if (in_clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = 1'b0;
      end
      out_d = ISSUE_IDLE;
    end else if (rdy) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].t1, ent_d[i].v1} = snoop({ent_q[i].t1, ent_q[i].v1},
                                             in_alu_tag, in_alu_value,
                                             in_lsb_tag, in_lsb_value);
          {ent_d[i].t2, ent_d[i].v2} = snoop({ent_q[i].t2, ent_q[i].v2},
                                             in_alu_tag, in_alu_value,
                                             in_lsb_tag, in_lsb_value);
        end
      end

      if (ready_found) begin
        out_d.op              = ent_q[ready_idx].op;
        out_d.value1          = ent_q[ready_idx].v1;
        out_d.value2          = ent_q[ready_idx].v2;
        out_d.imm             = ent_q[ready_idx].imm;
        out_d.pc              = ent_q[ready_idx].pc;
        out_d.rob_tag         = ent_q[ready_idx].rob_tag;
        ent_d[ready_idx].busy = 1'b0;
      end else begin
        out_d = ISSUE_IDLE;
      end

      // The free slot is chosen from registered state, so it never aliases
      // the entry being issued this edge.
      if (in_dispatch && free_found) begin
        ent_d[free_idx].busy    = 1'b1;
        ent_d[free_idx].op      = in_op;
        ent_d[free_idx].imm     = in_imm;
        ent_d[free_idx].pc      = in_pc;
        ent_d[free_idx].rob_tag = in_rob_tag;
        {ent_d[free_idx].t1, ent_d[free_idx].v1} = snoop({in_tag1, in_value1},
                                                         in_alu_tag, in_alu_value,
                                                         in_lsb_tag, in_lsb_value);
        {ent_d[free_idx].t2, ent_d[free_idx].v2} = snoop({in_tag2, in_value2},
                                                         in_alu_tag, in_alu_value,
                                                         in_lsb_tag, in_lsb_value);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      out_q <= ISSUE_IDLE;
    end else begin
      ent_q <= ent_d;
      out_q <= out_d;
    end
  end

  assign alu.op      = out_q.op;
  assign alu.value1  = out_q.value1;
  assign alu.value2  = out_q.value2;
  assign alu.imm     = out_q.imm;
  assign alu.pc      = out_q.pc;
  assign alu.rob_tag = out_q.rob_tag;

endmodule
